// File: rtl/ddr2_crc_pkg.sv
// rtl/ddr2_crc_pkg.sv - shared types and constants for the command CRC/replay front-end
package ddr2_crc_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int CRC_W8 = 8;
  localparam logic [7:0] POLY_CRC8 = 8'h07;

  localparam int CMD_W = 3;
  localparam int SZ_W  = 2;

  // Replay entry packs {retries, crc, sz, cmd, addr} with addr in the low bits.
  localparam int ADDR_LSB = 0;

  function automatic int cmd_lsb(input int aw);
    return aw;
  endfunction

  function automatic int sz_lsb(input int aw);
    return aw + CMD_W;
  endfunction

  function automatic int crc_lsb(input int aw);
    return aw + CMD_W + SZ_W;
  endfunction

  function automatic int retries_lsb(input int aw, input int cw);
    return aw + CMD_W + SZ_W + cw;
  endfunction

endpackage

// File: rtl/ddr2_cmd_crc_retry_if.sv
// rtl/ddr2_cmd_crc_retry_if.sv - host, issue and feedback handshake bundle
interface ddr2_cmd_crc_retry_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int CRC_W      = 8
);
  import ddr2_crc_pkg::*;

  logic [CMD_W-1:0]      host_cmd;
  logic [SZ_W-1:0]       host_sz;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic                  host_cmd_put;
  logic                  host_ready;

  logic [CMD_W-1:0]      ctrl_cmd;
  logic [SZ_W-1:0]       ctrl_sz;
  logic [ADDR_WIDTH-1:0] ctrl_addr;
  logic [CRC_W-1:0]      ctrl_crc;
  logic                  ctrl_cmd_put;
  logic                  ctrl_ready;

  logic                  fb_valid;
  logic                  fb_err;

  modport master (
    output host_cmd, host_sz, host_addr, host_cmd_put, ctrl_ready, fb_valid, fb_err,
    input  host_ready, ctrl_cmd, ctrl_sz, ctrl_addr, ctrl_crc, ctrl_cmd_put
  );

  modport slave (
    input  host_cmd, host_sz, host_addr, host_cmd_put, ctrl_ready, fb_valid, fb_err,
    output host_ready, ctrl_cmd, ctrl_sz, ctrl_addr, ctrl_crc, ctrl_cmd_put
  );

endinterface

// File: rtl/ddr2_crc_gen.sv
// rtl/ddr2_crc_gen.sv - combinational MSB-first CRC, bitwise LFSR fully unrolled
module ddr2_crc_gen
  import ddr2_crc_pkg::*;
#(
  parameter int               DATA_W   = 30,
  parameter int               CRC_W    = CRC_W8,
  parameter logic [CRC_W-1:0] CRC_POLY = POLY_CRC8,
  parameter logic [CRC_W-1:0] CRC_INIT = '0
) (
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc
);

  always_comb begin
    crc = CRC_INIT;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (crc[CRC_W-1] ^ data[i]) crc = (crc << 1) ^ CRC_POLY;
      else                        crc = crc << 1;
    end
  end

endmodule

// File: rtl/ddr2_cmd_crc_retry.sv
// rtl/ddr2_cmd_crc_retry.sv - command CRC tagging with go-back-N replay buffer
module ddr2_cmd_crc_retry
  import ddr2_crc_pkg::*;
#(
  parameter int               ADDR_WIDTH = 25,
  parameter int               DEPTH      = 8,
  parameter int               CRC_W      = CRC_W8,
  parameter logic [CRC_W-1:0] CRC_POLY   = POLY_CRC8,
  parameter logic [CRC_W-1:0] CRC_INIT   = '0,
  parameter int               MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  ddr2_cmd_crc_retry_if.slave   bus,
  output logic [15:0]           retry_total,
  output logic                  fatal_err,
  output logic [ADDR_WIDTH-1:0] fatal_addr,
  output logic                  proto_err
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);
  localparam int DATA_W    = CMD_W + SZ_W + ADDR_WIDTH;
  localparam int CMD_LSB   = cmd_lsb(ADDR_WIDTH);
  localparam int SZ_LSB    = sz_lsb(ADDR_WIDTH);
  localparam int CRC_LSB   = crc_lsb(ADDR_WIDTH);
  localparam int RETRY_LSB = retries_lsb(ADDR_WIDTH, CRC_W);
  localparam int ENTRY_W   = RETRY_LSB + RETRY_W;

  logic [ENTRY_W-1:0] mem [DEPTH];

  state_t                state, state_n;
  logic [PTR_W-1:0]      wr_ptr, iss_ptr, ack_ptr, drain_cnt;
  logic [PTR_W-1:0]      wr_n, iss_n, ack_n, drain_n;
  logic [15:0]           retry_total_n;
  logic                  fatal_err_n, proto_err_n;
  logic [ADDR_WIDTH-1:0] fatal_addr_n;

  logic [PTR_W-1:0]      used, inflight, pending;
  logic [IDX_W-1:0]      wr_idx, iss_idx, ack_idx;
  logic [CRC_W-1:0]      host_crc;
  logic [RETRY_W-1:0]    ack_retries;
  logic [ADDR_WIDTH-1:0] ack_addr;
  logic                  do_write, xfer, can_retry, rewind;

  ddr2_crc_gen #(
    .DATA_W   (DATA_W),
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .data ({bus.host_cmd, bus.host_sz, bus.host_addr}),
    .crc  (host_crc)
  );

  assign used     = wr_ptr - ack_ptr;
  assign inflight = iss_ptr - ack_ptr;
  assign pending  = wr_ptr - iss_ptr;
  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign iss_idx  = iss_ptr[IDX_W-1:0];
  assign ack_idx  = ack_ptr[IDX_W-1:0];

  assign ack_retries = mem[ack_idx][RETRY_LSB +: RETRY_W];
  assign ack_addr    = mem[ack_idx][ADDR_LSB +: ADDR_WIDTH];
  assign can_retry   = ack_retries < RETRY_W'(MAX_RETRY);

  assign bus.host_ready = (used != PTR_W'(DEPTH));
  assign do_write       = bus.host_cmd_put & bus.host_ready;

  // A replay rewinds iss this cycle, so any issue that would collide is withheld.
  assign rewind = (state == ST_RUN) & bus.fb_valid & bus.fb_err & (inflight != '0) & can_retry;

  assign bus.ctrl_cmd_put = (state == ST_RUN) & (pending != '0) & ~rewind;
  assign bus.ctrl_cmd     = mem[iss_idx][CMD_LSB +: CMD_W];
  assign bus.ctrl_sz      = mem[iss_idx][SZ_LSB +: SZ_W];
  assign bus.ctrl_addr    = mem[iss_idx][ADDR_LSB +: ADDR_WIDTH];
  assign bus.ctrl_crc     = mem[iss_idx][CRC_LSB +: CRC_W];
  assign xfer             = bus.ctrl_cmd_put & bus.ctrl_ready;

  always_comb begin
    state_n       = state;
    wr_n          = wr_ptr;
    iss_n         = iss_ptr;
    ack_n         = ack_ptr;
    drain_n       = drain_cnt;
    retry_total_n = retry_total;
    fatal_err_n   = fatal_err;
    fatal_addr_n  = fatal_addr;
    proto_err_n   = proto_err;

    if (do_write) wr_n = wr_ptr + PTR_W'(1);
    if (bus.host_cmd_put && !bus.host_ready) proto_err_n = 1'b1;
    if (xfer) iss_n = iss_ptr + PTR_W'(1);

    case (state)
      ST_RUN: begin
        if (bus.fb_valid) begin
          if (inflight == '0) begin
            proto_err_n = 1'b1;
          end else if (!bus.fb_err) begin
            ack_n = ack_ptr + PTR_W'(1);
          end else if (can_retry) begin
            if (retry_total != 16'hFFFF) retry_total_n = retry_total + 16'd1;
            if (inflight == PTR_W'(1)) begin
              iss_n = ack_ptr;
            end else begin
              drain_n = inflight - PTR_W'(1);
              state_n = ST_DRAIN;
            end
          end else begin
            ack_n       = ack_ptr + PTR_W'(1);
            fatal_err_n = 1'b1;
            if (!fatal_err) fatal_addr_n = ack_addr;
          end
        end
      end
      ST_DRAIN: begin
        // Feedback for commands issued after the failed one is stale; count it off.
        if (bus.fb_valid) begin
          if (drain_cnt == PTR_W'(1)) begin
            drain_n = '0;
            iss_n   = ack_ptr;
            state_n = ST_RUN;
          end else begin
            drain_n = drain_cnt - PTR_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      wr_ptr      <= '0;
      iss_ptr     <= '0;
      ack_ptr     <= '0;
      drain_cnt   <= '0;
      retry_total <= '0;
      fatal_err   <= 1'b0;
      fatal_addr  <= '0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_n;
      iss_ptr     <= iss_n;
      ack_ptr     <= ack_n;
      drain_cnt   <= drain_n;
      retry_total <= retry_total_n;
      fatal_err   <= fatal_err_n;
      fatal_addr  <= fatal_addr_n;
      proto_err   <= proto_err_n;
    end
  end

  // wr and ack slots never coincide while a retry is possible (used is neither 0 nor full).
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx] <= {RETRY_W'(0), host_crc, bus.host_sz, bus.host_cmd, bus.host_addr};
    if (rewind)   mem[ack_idx][RETRY_LSB +: RETRY_W] <= ack_retries + RETRY_W'(1);
  end

endmodule

// File: tb/tb_ddr2_cmd_crc_retry.sv
// tb/tb_ddr2_cmd_crc_retry.sv - directed and random checks against a queue-level reference model
module tb_ddr2_cmd_crc_retry;

  localparam int AW    = 25;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int MAXR  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   retry_total;
  logic          fatal_err;
  logic [AW-1:0] fatal_addr;
  logic          proto_err;

  ddr2_cmd_crc_retry_if #(.ADDR_WIDTH(AW), .CRC_W(CW)) bus();

  ddr2_cmd_crc_retry #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .CRC_W      (CW),
    .CRC_POLY   (8'h07),
    .CRC_INIT   (8'h00),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .retry_total (retry_total),
    .fatal_err   (fatal_err),
    .fatal_addr  (fatal_addr),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    cmd;
    logic [1:0]    sz;
    logic [AW-1:0] addr;
    int            retries;
  } ent_t;

  // Model: q holds unacknowledged commands oldest first; the first m_issued have been sent.
  ent_t          q[$];
  int            m_issued, m_discard, m_total;
  bit            m_fatal, m_proto;
  logic [AW-1:0] m_faddr;
  int            checks = 0;
  int            errors = 0;

  // CRC as the remainder of message * x^8 divided by x^8 + x^2 + x + 1.
  function automatic logic [7:0] ref_crc(input logic [2:0] c, input logic [1:0] s, input logic [AW-1:0] a);
    logic [AW+5+7:0] r;
    r = {c, s, a, 8'h00};
    for (int i = AW + 5 + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_chk(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL timeout_%s observed=expired expected=done", tag);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_issued  = 0;
    m_discard = 0;
    m_total   = 0;
    m_fatal   = 0;
    m_proto   = 0;
    m_faddr   = '0;
  endtask

  task automatic tick();
    bit   e_ready, e_put, rewind, xfer, pop;
    ent_t e;
    @(negedge clk);
    if (reset) model_clear();
    e_ready = (q.size() < DEPTH);
    rewind  = !reset && m_discard == 0 && bus.fb_valid && bus.fb_err && m_issued > 0 && q[0].retries < MAXR;
    e_put   = !reset && m_discard == 0 && m_issued < q.size() && !rewind;
    chk("host_ready", bus.host_ready, e_ready);
    chk("ctrl_cmd_put", bus.ctrl_cmd_put, e_put);
    if (e_put) begin
      e = q[m_issued];
      chk("ctrl_cmd", bus.ctrl_cmd, e.cmd);
      chk("ctrl_sz", bus.ctrl_sz, e.sz);
      chk("ctrl_addr", bus.ctrl_addr, e.addr);
      chk("ctrl_crc", bus.ctrl_crc, ref_crc(e.cmd, e.sz, e.addr));
    end
    chk("retry_total", retry_total, m_total);
    chk("fatal_err", fatal_err, m_fatal);
    chk("fatal_addr", fatal_addr, m_faddr);
    chk("proto_err", proto_err, m_proto);
    @(posedge clk);
    if (!reset) begin
      xfer = e_put && bus.ctrl_ready;
      pop  = 0;
      if (m_discard > 0) begin
        if (bus.fb_valid) begin
          m_discard--;
          if (m_discard == 0) m_issued = 0;
        end
      end else if (bus.fb_valid) begin
        if (m_issued == 0) m_proto = 1;
        else if (!bus.fb_err) pop = 1;
        else if (q[0].retries < MAXR) begin
          e = q[0];
          e.retries++;
          q[0] = e;
          if (m_total < 65535) m_total++;
          m_discard = m_issued - 1;
          if (m_discard == 0) m_issued = 0;
        end else begin
          if (!m_fatal) m_faddr = q[0].addr;
          m_fatal = 1;
          pop = 1;
        end
      end
      if (pop) begin
        void'(q.pop_front());
        m_issued--;
      end
      if (xfer) m_issued++;
      if (bus.host_cmd_put) begin
        if (e_ready) begin
          e.cmd = bus.host_cmd; e.sz = bus.host_sz; e.addr = bus.host_addr; e.retries = 0;
          q.push_back(e);
        end else m_proto = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.host_cmd_put = 1'b0;
    bus.fb_valid     = 1'b0;
    bus.fb_err       = 1'b0;
  endtask

  task automatic put(input logic [2:0] c, input logic [1:0] s, input logic [AW-1:0] a);
    bus.host_cmd = c; bus.host_sz = s; bus.host_addr = a; bus.host_cmd_put = 1'b1;
    tick();
    bus.host_cmd_put = 1'b0;
  endtask

  task automatic wait_issued(input int n);
    int k = 0;
    while (m_issued < n && k < 50) begin tick(); k++; end
    bound_chk("wait_issued", m_issued >= n);
  endtask

  task automatic drain_all();
    int k = 0;
    bus.ctrl_ready = 1'b1;
    while ((q.size() > 0 || m_discard > 0) && k < 300) begin
      bus.fb_valid = (m_discard > 0 || m_issued > 0);
      bus.fb_err   = 1'b0;
      tick();
      k++;
    end
    idle();
    bound_chk("drain_all", q.size() == 0 && m_discard == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] xa;
    bus.host_cmd = '0; bus.host_sz = '0; bus.host_addr = '0;
    bus.ctrl_ready = 1'b1;
    idle();
    model_clear();
    do_reset();
    chk("rst_host_ready", bus.host_ready, 1'b1);
    chk("rst_ctrl_cmd_put", bus.ctrl_cmd_put, 1'b0);

    // Three in-order commands, all acknowledged ok.
    for (int i = 0; i < 3; i++) put(3'd1, 2'd0, AW'(i));
    chk("first_issue_addr2", bus.ctrl_addr, AW'(2));
    chk("zero_cmd_crc", ref_crc(3'd1, 2'd0, '0) == 8'h00 ? 1'b0 : 1'b1, 1'b1);
    wait_issued(3);
    drain_all();

    // Spurious feedback with nothing in flight.
    bus.fb_valid = 1'b1; bus.fb_err = 1'b0;
    tick();
    idle();
    chk("spurious_proto", proto_err, 1'b1);
    put(3'd5, 2'd2, AW'(25'h1ABCDEF));
    drain_all();

    // Overflow: ninth put while full is dropped.
    do_reset();
    bus.ctrl_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) put(3'($urandom), 2'($urandom), AW'($urandom));
    chk("full_host_ready", bus.host_ready, 1'b0);
    chk("overflow_proto", proto_err, 1'b1);
    drain_all();

    // Go-back-N: error on A discards B and C feedback, then A,B,C reissue.
    do_reset();
    for (int i = 0; i < 3; i++) put(3'd2, 2'd1, AW'(16 + i));
    wait_issued(3);
    bus.fb_valid = 1'b1; bus.fb_err = 1'b1;
    tick();
    bus.fb_err = 1'b0;
    tick();
    tick();
    idle();
    wait_issued(3);
    chk("gbn_retry_total", retry_total, 16'd1);
    drain_all();

    // Exhausted retries drop the head and record its address.
    do_reset();
    xa = AW'(25'h0ABCDE);
    put(3'd3, 2'd3, xa);
    put(3'd4, 2'd0, AW'(25'h1000001));
    wait_issued(2);
    for (int r = 0; r < MAXR + 1; r++) begin
      bus.fb_valid = 1'b1; bus.fb_err = 1'b1;
      tick();
      bus.fb_err = 1'b0;
      while (m_discard > 0) tick();
      idle();
      if (r < MAXR) wait_issued(2);
    end
    chk("drop_fatal_err", fatal_err, 1'b1);
    chk("drop_fatal_addr", fatal_addr, xa);
    chk("drop_retry_total", retry_total, 16'(MAXR));
    drain_all();

    // Randomised traffic.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.host_cmd     = 3'($urandom);
      bus.host_sz      = 2'($urandom);
      bus.host_addr    = AW'($urandom);
      bus.host_cmd_put = ($urandom_range(0, 2) == 0);
      bus.ctrl_ready   = ($urandom_range(0, 3) != 0);
      bus.fb_valid     = (m_discard > 0 || m_issued > 0) && ($urandom_range(0, 1) == 1);
      bus.fb_err       = ($urandom_range(0, 5) == 0);
      tick();
    end
    idle();
    drain_all();

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 5; i++) put(3'd6, 2'd2, AW'($urandom));
    wait_issued(5);
    bus.fb_valid = 1'b1; bus.fb_err = 1'b1;
    tick();
    idle();
    tick();
    reset = 1'b1;
    #2;
    chk("midrst_host_ready", bus.host_ready, 1'b1);
    chk("midrst_ctrl_cmd_put", bus.ctrl_cmd_put, 1'b0);
    chk("midrst_retry_total", retry_total, 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("postrst_ctrl_cmd_put", bus.ctrl_cmd_put, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
